rd_frame_buf: RTL and testbench

- True dual-port, single-clock block RAM used as the line buffer of the video read path.
- Port A is written with DDR read-burst beats. Port B is read by the pixel output logic.
- Both ports can read and write. Each port has a synchronous read with one-cycle latency.
- Default geometry is 1024 words x 128 bits.

---
 rtl/rd_frame_buf_pkg.sv | 9 +
 rtl/rd_frame_buf_if.sv | 34 +++
 rtl/rd_frame_buf.sv | 43 ++++
 tb/tb_rd_frame_buf.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rd_frame_buf_pkg.sv
// Shared geometry for the rd_buf video line buffer.
// Default word width and address width used by the RAM and its bus interface.
package rd_frame_buf_pkg;

    localparam int RD_BUF_DATA_WIDTH = 128;
    localparam int RD_BUF_ADDR_WIDTH = 10;
    localparam int RD_BUF_DEPTH      = 2 ** RD_BUF_ADDR_WIDTH;

endpackage : rd_frame_buf_pkg

// File: rtl/rd_frame_buf_if.sv
// Bus bundle for the two RAM ports of rd_frame_buf.
// The slave modport is the RAM side; the master modport is the DDR writer / pixel reader side.
interface rd_frame_buf_if
    import rd_frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = RD_BUF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RD_BUF_ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wr_data;
    logic                  a_wr_en;
    logic [DATA_WIDTH-1:0] a_rd_data;

    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wr_data;
    logic                  b_wr_en;
    logic [DATA_WIDTH-1:0] b_rd_data;

    modport slave (
        input  a_addr, a_wr_data, a_wr_en,
        output a_rd_data,
        input  b_addr, b_wr_data, b_wr_en,
        output b_rd_data
    );

    modport master (
        output a_addr, a_wr_data, a_wr_en,
        input  a_rd_data,
        output b_addr, b_wr_data, b_wr_en,
        input  b_rd_data
    );

endinterface : rd_frame_buf_if

// File: rtl/rd_frame_buf.sv
// True dual-port, single-clock line buffer RAM for the video read path.
// Both ports read-first with one-cycle registered read data; port B wins a same-address dual write.
module rd_frame_buf
    import rd_frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = RD_BUF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RD_BUF_ADDR_WIDTH
) (
    input  logic           a_clk,
    input  logic           a_rst,
    rd_frame_buf_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_rd_q;
    logic [DATA_WIDTH-1:0] b_rd_q;

    // NOTE: the array has no reset branch so it maps onto block RAM; only the read registers reset.
    always_ff @(posedge a_clk) begin
        if (!a_rst) begin
            // NOTE: non-blocking writes keep every same-edge read on the old contents (read-first).
            if (bus.a_wr_en) mem[bus.a_addr] <= bus.a_wr_data;
            // Applied after port A, so port B owns a same-address collision.
            if (bus.b_wr_en) mem[bus.b_addr] <= bus.b_wr_data;
        end
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) a_rd_q <= '0;
        else       a_rd_q <= mem[bus.a_addr];
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) b_rd_q <= '0;
        else       b_rd_q <= mem[bus.b_addr];
    end

    assign bus.a_rd_data = a_rd_q;
    assign bus.b_rd_data = b_rd_q;

endmodule : rd_frame_buf

// File: tb/tb_rd_frame_buf.sv
// Scoreboard bench for rd_frame_buf: the driver queues expected read data per port each cycle,
// a monitor pops and compares one cycle later.
module tb_rd_frame_buf;

    import rd_frame_buf_pkg::*;

    localparam int DW = RD_BUF_DATA_WIDTH;
    localparam int AW = RD_BUF_ADDR_WIDTH;

    typedef struct {
        bit          chk;
        logic [DW-1:0] data;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [DW-1:0] model [int];

    bit            ov_a_en = 1'b0;
    bit            ov_b_en = 1'b0;
    logic [DW-1:0] ov_a;
    logic [DW-1:0] ov_b;

    rd_frame_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rd_frame_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .a_clk (clk),
        .a_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int addr);
        logic [AW-1:0] a;
        a = addr[AW-1:0];
        return {4{a, 22'h0}};
    endfunction

    function automatic exp_t make_exp(input int addr, input bit ov_en, input logic [DW-1:0] ov,
                                      input string name);
        exp_t e;
        e.name = name;
        e.chk  = 1'b0;
        e.data = '0;
        if (rst) begin
            e.chk = 1'b1;
        end else if (ov_en) begin
            e.chk  = 1'b1;
            e.data = ov;
        end else if (model.exists(addr)) begin
            e.chk  = 1'b1;
            e.data = model[addr];
        end
        return e;
    endfunction

    // Called at a falling edge: drives one cycle on both ports and queues the expected read data.
    task automatic cyc(input int aa, input logic [DW-1:0] awd, input bit awe,
                       input int ba, input logic [DW-1:0] bwd, input bit bwe,
                       input string tag);
        exp_t ea;
        exp_t eb;
        bus.a_addr    = aa[AW-1:0];
        bus.a_wr_data = awd;
        bus.a_wr_en   = awe;
        bus.b_addr    = ba[AW-1:0];
        bus.b_wr_data = bwd;
        bus.b_wr_en   = bwe;
        ea = make_exp(aa, ov_a_en, ov_a, {tag, "_a"});
        eb = make_exp(ba, ov_b_en, ov_b, {tag, "_b"});
        ov_a_en = 1'b0;
        ov_b_en = 1'b0;
        if (!rst) begin
            if (awe) model[aa] = awd;
            if (bwe) model[ba] = bwd;
        end
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(posedge clk);
        @(negedge clk);
        bus.a_wr_en = 1'b0;
        bus.b_wr_en = 1'b0;
    endtask

    task automatic expect_a(input logic [DW-1:0] v);
        ov_a_en = 1'b1;
        ov_a    = v;
    endtask

    task automatic expect_b(input logic [DW-1:0] v);
        ov_b_en = 1'b1;
        ov_b    = v;
    endtask

    // Monitor: read data is compared just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                if (e.chk) check(e.name, bus.a_rd_data, e.data);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                if (e.chk) check(e.name, bus.b_rd_data, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    localparam logic [DW-1:0] DEAD   = 128'hDEAD_BEEF_0000_0000_1234_5678_CAFE_F00D;
    localparam logic [DW-1:0] PAT4   = 128'h0100_0000_0100_0000_0100_0000_0100_0000;
    localparam logic [DW-1:0] OLD7   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [DW-1:0] NEW7   = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [DW-1:0] TOP_W  = 128'hAAAA_0000_0000_0000_0000_0000_0000_03FF;
    localparam logic [DW-1:0] BOT_W  = 128'h5555_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [DW-1:0] ONE    = 128'h1;
    localparam logic [DW-1:0] TWO    = 128'h2;
    localparam logic [DW-1:0] JUNK   = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

    initial begin
        bus.a_addr    = '0;
        bus.a_wr_data = '0;
        bus.a_wr_en   = 1'b0;
        bus.b_addr    = '0;
        bus.b_wr_data = '0;
        bus.b_wr_en   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_a", bus.a_rd_data, '0);
        check("reset_b", bus.b_rd_data, '0);
        rst = 1'b0;

        // Fill every word through port A, then read it all back through port B
        for (int i = 0; i < 2 ** AW; i++) cyc(i, pat(i), 1'b1, 0, '0, 1'b0, "fill");
        for (int i = 0; i < 2 ** AW; i++) cyc(0, '0, 1'b0, i, '0, 1'b0, "sweep");

        // Latency: address 4 then 5 on port B, literal expectations
        cyc(5, DEAD, 1'b1, 0, '0, 1'b0, "lat_wr");
        expect_b(PAT4);
        cyc(0, '0, 1'b0, 4, '0, 1'b0, "lat_prev");
        check("lat_hold_before_edge", bus.b_rd_data, PAT4);
        expect_b(DEAD);
        cyc(0, '0, 1'b0, 5, '0, 1'b0, "lat_new");

        // Read-during-write on address 7, same-port and cross-port
        cyc(7, OLD7, 1'b1, 0, '0, 1'b0, "rdw_init");
        expect_a(OLD7);
        expect_b(OLD7);
        cyc(7, NEW7, 1'b1, 7, '0, 1'b0, "rdw_edge");
        expect_a(NEW7);
        expect_b(NEW7);
        cyc(7, '0, 1'b0, 7, '0, 1'b0, "rdw_next");

        // Top and bottom addresses do not alias
        cyc(1023, TOP_W, 1'b1, 0, '0, 1'b0, "wrap_wr_top");
        cyc(0, BOT_W, 1'b1, 0, '0, 1'b0, "wrap_wr_bot");
        expect_a(BOT_W);
        expect_b(TOP_W);
        cyc(0, '0, 1'b0, 1023, '0, 1'b0, "wrap_rd1");
        expect_a(TOP_W);
        expect_b(BOT_W);
        cyc(1023, '0, 1'b0, 0, '0, 1'b0, "wrap_rd2");

        // Dual write to address 9: port B wins
        cyc(9, ONE, 1'b1, 9, TWO, 1'b1, "dual_wr");
        expect_a(TWO);
        expect_b(TWO);
        cyc(9, '0, 1'b0, 9, '0, 1'b0, "dual_rd");

        // Port B write, port A read
        cyc(0, '0, 1'b0, 300, NEW7, 1'b1, "b_wr");
        expect_a(NEW7);
        cyc(300, '0, 1'b0, 301, '0, 1'b0, "b_wr_rd");

        // Asynchronous reset mid-cycle, write suppression, and resume
        cyc(5, '0, 1'b0, 7, '0, 1'b0, "pre_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a", bus.a_rd_data, '0);
        check("async_rst_b", bus.b_rd_data, '0);
        @(negedge clk);
        cyc(20, JUNK, 1'b1, 21, JUNK, 1'b1, "rst_wr");
        check("rst_hold_a", bus.a_rd_data, '0);
        rst = 1'b0;
        #1;
        check("rel_before_edge_b", bus.b_rd_data, '0);
        @(negedge clk);
        expect_a(pat(20));
        expect_b(pat(21));
        cyc(20, '0, 1'b0, 21, '0, 1'b0, "post_rst");

        @(posedge clk);
        #3;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rd_frame_buf
